pmp_csr_file: RTL and testbench

PMP_CSR_FILE -- requirements
Module: pmp_csr_file

---
 rtl/pmp_pkg.sv | 42 ++++
 rtl/pmp_cfg_wr.sv | 13 +
 rtl/pmp_csr_file.sv | 141 ++++++++++++++
 tb/tb_pmp_csr_file.sv | 241 ++++++++++++++++++++++++
 4 files changed

// File: rtl/pmp_pkg.sv
// Shared PMP definitions: cfg byte layout, privilege / A-mode encodings, CSR map.
package pmp_pkg;

    localparam logic [1:0] PRV_U = 2'b00;
    localparam logic [1:0] PRV_S = 2'b01;
    localparam logic [1:0] PRV_M = 2'b11;

    localparam logic [1:0] PMP_OFF   = 2'b00;
    localparam logic [1:0] PMP_TOR   = 2'b01;
    localparam logic [1:0] PMP_NA4   = 2'b10;
    localparam logic [1:0] PMP_NAPOT = 2'b11;

    localparam logic [11:0] CSR_PMPCFG0  = 12'h3A0;
    localparam logic [11:0] CSR_PMPADDR0 = 12'h3B0;

    localparam int CFG_WORDS   = 4;
    localparam int MAX_ENTRIES = 16;

    typedef struct packed {
        logic       l;
        logic [1:0] res;
        logic [1:0] a;
        logic       x;
        logic       w;
        logic       r;
    } pmpcfg_t;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RESP = 1'b1
    } csr_state_e;

    // Legalise a written cfg byte: reserved bits read zero, W=1 with R=0 is not allowed.
    function automatic pmpcfg_t cfg_warl(input logic [7:0] b);
        pmpcfg_t c;
        c     = pmpcfg_t'(b);
        c.res = 2'b00;
        if (!c.r) c.w = 1'b0;
        return c;
    endfunction

endpackage

// File: rtl/pmp_cfg_wr.sv
// Next value of one pmpcfg byte: locked bytes hold, written bytes are legalised.
module pmp_cfg_wr
    import pmp_pkg::*;
(
    input  pmpcfg_t    cfg_old,
    input  logic       wen,
    input  logic [7:0] wbyte,
    output pmpcfg_t    cfg_new
);

    assign cfg_new = (wen && !cfg_old.l) ? cfg_warl(wbyte) : cfg_old;

endmodule

// File: rtl/pmp_csr_file.sv
// PMP cfg/addr CSR file: single-outstanding request/response port, lock and WARL handling.
module pmp_csr_file
    import pmp_pkg::*;
#(
    parameter int         PMP_CNT   = 16,
    parameter int         VLEN      = 31,
    parameter logic [1:0] U_MODE    = PRV_U,
    parameter logic [1:0] S_MODE    = PRV_S,
    parameter logic [1:0] M_MODE    = PRV_M,
    parameter logic [1:0] A0_OFF    = PMP_OFF,
    parameter logic [1:0] A1_TOR    = PMP_TOR,
    parameter logic [1:0] A2_NA4    = PMP_NA4,
    parameter logic [1:0] A3_NAPOT  = PMP_NAPOT
) (
    input  logic                             clock,
    input  logic                             reset_n,
    input  logic                             io_csr_req,
    output logic                             io_csr_ready,
    input  logic                             io_csr_we,
    input  logic [11:0]                      io_csr_addr,
    input  logic [31:0]                      io_csr_wdata,
    input  logic [1:0]                       io_prv,
    output logic                             io_csr_rvalid,
    output logic [31:0]                      io_csr_rdata,
    output logic                             io_csr_illegal,
    output pmpcfg_t [PMP_CNT-1:0]            io_pmpcfg,
    output logic [PMP_CNT-1:0][VLEN:0]       io_pmpaddr,
    output logic                             io_cfg_update
);

    if (PMP_CNT < 1 || PMP_CNT > MAX_ENTRIES || VLEN > 31) begin : g_bad_size
        $error("pmp_csr_file: PMP_CNT must be 1..16 and VLEN at most 31");
    end
    if (U_MODE == M_MODE || S_MODE == M_MODE || U_MODE == S_MODE) begin : g_bad_prv
        $error("pmp_csr_file: privilege encodings must be distinct");
    end
    if (A0_OFF == A1_TOR || A2_NA4 == A1_TOR || A3_NAPOT == A1_TOR ||
        A0_OFF == A2_NA4 || A0_OFF == A3_NAPOT || A2_NA4 == A3_NAPOT) begin : g_bad_amode
        $error("pmp_csr_file: A-mode encodings must be distinct");
    end

    csr_state_e state_q, state_d;

    pmpcfg_t [MAX_ENTRIES-1:0]         cfg_q, cfg_d, cfg_wr;
    logic    [MAX_ENTRIES-1:0][VLEN:0] addr_q, addr_d;

    logic [31:0] rdata_q, rd_val;
    logic        illegal_q, update_q;
    logic        is_cfg, is_addr, illegal, accept, wr_ok;

    assign is_cfg  = (io_csr_addr[11:2] == CSR_PMPCFG0[11:2]);
    assign is_addr = (io_csr_addr[11:4] == CSR_PMPADDR0[11:4]);
    assign illegal = (io_prv != M_MODE) || !(is_cfg || is_addr);
    assign accept  = (state_q == ST_IDLE) && io_csr_req;
    assign wr_ok   = accept && io_csr_we && !illegal;

    always_comb begin
        state_d       = state_q;
        io_csr_ready  = 1'b0;
        io_csr_rvalid = 1'b0;
        case (state_q)
            ST_IDLE: begin
                io_csr_ready = 1'b1;
                if (io_csr_req) state_d = ST_RESP;
            end
            ST_RESP: begin
                io_csr_rvalid = 1'b1;
                state_d       = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        rd_val = '0;
        if (is_cfg) begin
            for (int k = 0; k < 4; k++)
                rd_val[8*k +: 8] = cfg_q[{io_csr_addr[1:0], 2'(k)}];
        end else if (is_addr) begin
            rd_val = 32'(addr_q[io_csr_addr[3:0]]);
        end
    end

    // Four byte writers per pmpcfg word; entries past PMP_CNT are tied off below.
    for (genvar w = 0; w < CFG_WORDS; w++) begin : g_word
        logic word_wen;
        assign word_wen = wr_ok && is_cfg && (io_csr_addr[1:0] == 2'(w));
        for (genvar k = 0; k < 4; k++) begin : g_byte
            pmp_cfg_wr u_cfg_wr (
                .cfg_old (cfg_q[4*w+k]),
                .wen     (word_wen),
                .wbyte   (io_csr_wdata[8*k +: 8]),
                .cfg_new (cfg_wr[4*w+k])
            );
        end
    end

    for (genvar i = 0; i < MAX_ENTRIES; i++) begin : g_entry
        logic addr_lock, addr_wen;
        // A locked TOR entry above also freezes this address, since it is that entry's base.
        if (i < MAX_ENTRIES-1) begin : g_tor
            assign addr_lock = cfg_q[i].l || (cfg_q[i+1].l && cfg_q[i+1].a == A1_TOR);
        end else begin : g_top
            assign addr_lock = cfg_q[i].l;
        end
        assign addr_wen = wr_ok && is_addr && (io_csr_addr[3:0] == 4'(i)) && !addr_lock;
        if (i < PMP_CNT) begin : g_live
            assign cfg_d[i]  = cfg_wr[i];
            assign addr_d[i] = addr_wen ? io_csr_wdata[VLEN:0] : addr_q[i];
        end else begin : g_tie
            assign cfg_d[i]  = '0;
            assign addr_d[i] = '0;
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= ST_IDLE;
            cfg_q     <= '0;
            addr_q    <= '0;
            rdata_q   <= '0;
            illegal_q <= 1'b0;
            update_q  <= 1'b0;
        end else begin
            state_q   <= state_d;
            cfg_q     <= cfg_d;
            addr_q    <= addr_d;
            rdata_q   <= (accept && !illegal) ? rd_val : '0;
            illegal_q <= accept && illegal;
            // Next equals current on every cycle without an accepted write.
            update_q  <= (cfg_d != cfg_q) || (addr_d != addr_q);
        end
    end

    assign io_csr_rdata   = rdata_q;
    assign io_csr_illegal = illegal_q;
    assign io_cfg_update  = update_q;
    assign io_pmpcfg      = cfg_q[PMP_CNT-1:0];
    assign io_pmpaddr     = addr_q[PMP_CNT-1:0];

endmodule

// File: tb/tb_pmp_csr_file.sv
// Vector table + response scoreboard for pmp_csr_file.
module tb_pmp_csr_file;
    import pmp_pkg::*;

    logic                 clock, reset_n;
    logic                 io_csr_req, io_csr_ready, io_csr_we;
    logic [11:0]          io_csr_addr;
    logic [31:0]          io_csr_wdata;
    logic [1:0]           io_prv;
    logic                 io_csr_rvalid, io_csr_illegal, io_cfg_update;
    logic [31:0]          io_csr_rdata;
    pmpcfg_t [15:0]       io_pmpcfg;
    logic [15:0][31:0]    io_pmpaddr;

    pmp_csr_file dut (
        .clock          (clock),
        .reset_n        (reset_n),
        .io_csr_req     (io_csr_req),
        .io_csr_ready   (io_csr_ready),
        .io_csr_we      (io_csr_we),
        .io_csr_addr    (io_csr_addr),
        .io_csr_wdata   (io_csr_wdata),
        .io_prv         (io_prv),
        .io_csr_rvalid  (io_csr_rvalid),
        .io_csr_rdata   (io_csr_rdata),
        .io_csr_illegal (io_csr_illegal),
        .io_pmpcfg      (io_pmpcfg),
        .io_pmpaddr     (io_pmpaddr),
        .io_cfg_update  (io_cfg_update)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    typedef struct {
        logic        we;
        logic [11:0] addr;
        logic [31:0] wdata;
        logic [1:0]  prv;
        logic [31:0] rdata;
        logic        ill;
        logic        upd;
        int          kind;   // 0 none, 1 cfg entry, 2 addr entry
        int          idx;
        logic [31:0] val;
    } vec_t;

    typedef struct {
        int          id;
        logic [31:0] rdata;
        logic        ill;
        logic        upd;
    } exp_t;

    vec_t vecs[$];
    exp_t sb[$];
    int   n_chk  = 0;
    int   n_fail = 0;
    bit   mon_en = 1'b1;
    int   vec_id = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    always @(negedge clock) begin
        if (mon_en && reset_n && io_csr_rvalid) begin
            if (sb.size() == 0) begin
                check("unexpected_rvalid", 32'd1, 32'd0);
            end else begin
                exp_t e;
                e = sb.pop_front();
                check($sformatf("resp%0d_rdata", e.id), io_csr_rdata, e.rdata);
                check($sformatf("resp%0d_illegal", e.id), 32'(io_csr_illegal), 32'(e.ill));
                check($sformatf("resp%0d_update", e.id), 32'(io_cfg_update), 32'(e.upd));
            end
        end
    end

    task automatic add(input logic we, input logic [11:0] addr, input logic [31:0] wdata,
                       input logic [1:0] prv, input logic [31:0] rdata, input logic ill,
                       input logic upd, input int kind, input int idx, input logic [31:0] val);
        vec_t v;
        v = '{we, addr, wdata, prv, rdata, ill, upd, kind, idx, val};
        vecs.push_back(v);
    endtask

    task automatic wait_ready();
        int n = 0;
        while (!io_csr_ready && n < 8) begin
            @(negedge clock);
            n++;
        end
        if (!io_csr_ready) check("ready_timeout", 32'(io_csr_ready), 32'd1);
    endtask

    task automatic run_vec(input vec_t v);
        exp_t e;
        wait_ready();
        io_csr_req   = 1'b1;
        io_csr_we    = v.we;
        io_csr_addr  = v.addr;
        io_csr_wdata = v.wdata;
        io_prv       = v.prv;
        e = '{vec_id, v.rdata, v.ill, v.upd};
        sb.push_back(e);
        @(negedge clock);
        check($sformatf("vec%0d_rvalid", vec_id), 32'(io_csr_rvalid), 32'd1);
        if (v.kind == 1)
            check($sformatf("vec%0d_cfg%0d", vec_id, v.idx), 32'(io_pmpcfg[v.idx]), v.val);
        else if (v.kind == 2)
            check($sformatf("vec%0d_addr%0d", vec_id, v.idx), io_pmpaddr[v.idx], v.val);
        io_csr_req = 1'b0;
        io_csr_we  = 1'b0;
        @(negedge clock);
        vec_id++;
    endtask

    localparam logic [1:0] M = 2'b11, S = 2'b01, U = 2'b00;

    initial begin
        reset_n      = 1'b0;
        io_csr_req   = 1'b0;
        io_csr_we    = 1'b0;
        io_csr_addr  = '0;
        io_csr_wdata = '0;
        io_prv       = M;

        //  we  addr    wdata         prv rdata         ill upd kind idx val
        add(1, 12'h3A0, 32'h00001F0F, M, 32'h00000000, 0, 1, 1, 1,  32'h1F);
        add(0, 12'h3A0, 32'h0,        M, 32'h00001F0F, 0, 0, 1, 0,  32'h0F);
        add(1, 12'h3A1, 32'h00006A42, M, 32'h00000000, 0, 1, 1, 5,  32'h08);
        add(0, 12'h3A1, 32'h0,        M, 32'h00000800, 0, 0, 1, 4,  32'h00);
        add(1, 12'h3A0, 32'h00881F0F, M, 32'h00001F0F, 0, 1, 1, 2,  32'h88);
        add(1, 12'h3B2, 32'h00001234, M, 32'h00000000, 0, 0, 2, 2,  32'h0);
        add(1, 12'h3A0, 32'h00000000, M, 32'h00881F0F, 0, 1, 1, 2,  32'h88);
        add(1, 12'h3B1, 32'h00004444, M, 32'h00000000, 0, 0, 2, 1,  32'h0);
        add(1, 12'h3B4, 32'h0000CAFE, M, 32'h00000000, 0, 1, 2, 4,  32'hCAFE);
        add(1, 12'h3A0, 32'h89000000, M, 32'h00880000, 0, 1, 1, 3,  32'h89);
        add(1, 12'h3B2, 32'h0000ABCD, M, 32'h00000000, 0, 0, 2, 2,  32'h0);
        add(1, 12'h3B4, 32'h00005555, M, 32'h0000CAFE, 0, 1, 2, 4,  32'h5555);
        add(1, 12'h3A1, 32'h00880000, M, 32'h00000800, 0, 1, 1, 6,  32'h88);
        add(1, 12'h3B5, 32'h00000077, M, 32'h00000000, 0, 0, 2, 5,  32'h0);
        add(1, 12'h3B7, 32'h00000099, M, 32'h00000000, 0, 1, 2, 7,  32'h99);
        add(0, 12'h3B0, 32'h0,        U, 32'h00000000, 1, 0, 0, 0,  32'h0);
        add(1, 12'h3B0, 32'h000000FF, U, 32'h00000000, 1, 0, 2, 0,  32'h0);
        add(1, 12'h3A1, 32'h00000000, S, 32'h00000000, 1, 0, 1, 6,  32'h88);
        add(0, 12'h3C0, 32'h0,        M, 32'h00000000, 1, 0, 0, 0,  32'h0);
        add(0, 12'h3A4, 32'h0,        M, 32'h00000000, 1, 0, 0, 0,  32'h0);
        add(0, 12'h3AF, 32'h0,        M, 32'h00000000, 1, 0, 0, 0,  32'h0);
        add(1, 12'h3B4, 32'h00005555, M, 32'h00005555, 0, 0, 2, 4,  32'h5555);
        add(1, 12'h3B8, 32'hFFFFFFFF, M, 32'h00000000, 0, 1, 2, 8,  32'hFFFFFFFF);
        add(0, 12'h3B8, 32'h0,        M, 32'hFFFFFFFF, 0, 0, 0, 0,  32'h0);
        add(1, 12'h3A3, 32'h00000081, M, 32'h00000000, 0, 1, 1, 12, 32'h81);
        add(1, 12'h3BB, 32'h00000010, M, 32'h00000000, 0, 1, 2, 11, 32'h10);
        add(1, 12'h3BC, 32'h00000020, M, 32'h00000000, 0, 0, 2, 12, 32'h0);

        repeat (2) @(negedge clock);
        check("rst_ready",   32'(io_csr_ready), 32'd1);
        check("rst_rvalid",  32'(io_csr_rvalid), 32'd0);
        check("rst_rdata",   io_csr_rdata, 32'd0);
        check("rst_illegal", 32'(io_csr_illegal), 32'd0);
        check("rst_update",  32'(io_cfg_update), 32'd0);
        check("rst_cfg",     32'(|io_pmpcfg), 32'd0);
        check("rst_addr",    32'(|io_pmpaddr), 32'd0);
        reset_n = 1'b1;
        @(negedge clock);

        foreach (vecs[i]) run_vec(vecs[i]);

        // Request held for three cycles: accepted on the first and third only.
        io_csr_req  = 1'b1;
        io_csr_we   = 1'b0;
        io_csr_addr = 12'h3B4;
        io_prv      = M;
        check("hold_c0_ready", 32'(io_csr_ready), 32'd1);
        sb.push_back('{100, 32'h5555, 1'b0, 1'b0});
        @(negedge clock);
        check("hold_c1_ready", 32'(io_csr_ready), 32'd0);
        check("hold_c1_rvalid", 32'(io_csr_rvalid), 32'd1);
        @(negedge clock);
        check("hold_c2_ready", 32'(io_csr_ready), 32'd1);
        check("hold_c2_rvalid", 32'(io_csr_rvalid), 32'd0);
        sb.push_back('{101, 32'h5555, 1'b0, 1'b0});
        @(negedge clock);
        io_csr_req = 1'b0;
        check("hold_c3_rvalid", 32'(io_csr_rvalid), 32'd1);
        @(negedge clock);
        check("hold_c4_rvalid", 32'(io_csr_rvalid), 32'd0);
        check("sb_drained", 32'(sb.size()), 32'd0);

        // Reset while a response is on the port.
        mon_en       = 1'b0;
        io_csr_req   = 1'b1;
        io_csr_we    = 1'b1;
        io_csr_addr  = 12'h3B7;
        io_csr_wdata = 32'h1;
        @(negedge clock);
        io_csr_req = 1'b0;
        io_csr_we  = 1'b0;
        check("abort_pre_rvalid", 32'(io_csr_rvalid), 32'd1);
        reset_n = 1'b0;
        #1;
        check("abort_rvalid",  32'(io_csr_rvalid), 32'd0);
        check("abort_ready",   32'(io_csr_ready), 32'd1);
        check("abort_update",  32'(io_cfg_update), 32'd0);
        check("abort_cfg",     32'(|io_pmpcfg), 32'd0);
        check("abort_addr",    32'(|io_pmpaddr), 32'd0);
        @(negedge clock);
        reset_n = 1'b1;
        @(negedge clock);
        check("post_rst_rvalid", 32'(io_csr_rvalid), 32'd0);
        check("post_rst_ready",  32'(io_csr_ready), 32'd1);
        @(negedge clock);
        check("post_rst_no_replay", 32'(io_csr_rvalid), 32'd0);
        mon_en = 1'b1;

        begin
            vec_t v;
            v = '{1'b0, 12'h3A0, 32'h0, M, 32'h0, 1'b0, 1'b0, 0, 0, 32'h0};
            run_vec(v);
            v = '{1'b1, 12'h3B2, 32'h1234, M, 32'h0, 1'b0, 1'b1, 2, 2, 32'h1234};
            run_vec(v);
        end
        check("sb_final_empty", 32'(sb.size()), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1, "timeout");
    end

endmodule
